// File: rtl/color_button_scanner.sv
// Color-button matrix scanner: drives active-low rows, debounces the shared
// return line per row, and keeps a toggle lamp state per button.
module color_button_scanner #(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned DEBOUNCE_N = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sense,
   input  logic       i_clear,
   output logic [3:0] o_scan,
   output logic [3:0] o_press,
   output logic [3:0] o_pressed,
   output logic [3:0] o_led_n
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_row;
   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt [4];
   logic [3:0]       r_stable;
   logic [3:0]       r_press;
   logic [3:0]       r_led;

   logic             w_wrap;
   logic             w_raw;
   logic [CNT_W-1:0] w_cnt_nxt [4];
   logic [3:0]       w_stable_nxt;
   logic [3:0]       w_rise;

   assign w_wrap = (r_div == DIV_LAST);
   assign w_raw  = ~r_sync2;

   // Only the row selected during the finishing dwell is sampled, on its wrap cycle.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_stable_nxt = r_stable;
      if (w_wrap) begin
         if (w_raw == r_stable[r_row]) begin
            w_cnt_nxt[r_row] = '0;
         end else if (r_cnt[r_row] == CNT_LAST) begin
            w_stable_nxt[r_row] = w_raw;
            w_cnt_nxt[r_row]    = '0;
         end else begin
            w_cnt_nxt[r_row] = r_cnt[r_row] + CNT_W'(1);
         end
      end
      w_rise = w_stable_nxt & ~r_stable;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div    <= '0;
         r_row    <= '0;
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_cnt    <= '{default: '0};
         r_stable <= '0;
         r_press  <= '0;
         r_led    <= '1;
      end else begin
         r_div    <= w_wrap ? '0 : r_div + DIV_W'(1);
         if (w_wrap) begin
            r_row <= r_row + 2'd1;
         end
         r_sync1  <= i_sense;
         r_sync2  <= r_sync1;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
         r_press  <= w_rise;
         // Clear overrides a simultaneous toggle; the press pulse still goes out.
         r_led    <= i_clear ? '1 : (r_led ^ w_rise);
      end
   end

   assign o_scan    = ~(4'b0001 << r_row);
   assign o_press   = r_press;
   assign o_pressed = r_stable;
   assign o_led_n   = r_led;

endmodule

// File: tb/tb_color_button_scanner.sv
// Directed bench for color_button_scanner with SCAN_DIV=4, DEBOUNCE_N=4;
// a held button pulls the return line low while its row is selected.
module tb_color_button_scanner;

   logic       clk;
   logic       rst_n;
   logic       i_sense;
   logic       i_clear;
   logic [3:0] o_scan;
   logic [3:0] o_press;
   logic [3:0] o_pressed;
   logic [3:0] o_led_n;

   logic [3:0] held_mask;

   color_button_scanner #(
      .SCAN_DIV  (4),
      .DEBOUNCE_N(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sense  (i_sense),
      .i_clear  (i_clear),
      .o_scan   (o_scan),
      .o_press  (o_press),
      .o_pressed(o_pressed),
      .o_led_n  (o_led_n)
   );

   assign i_sense = ~|(~o_scan & held_mask);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic       clr;
      logic [3:0] scan;
      logic [3:0] press;
      logic [3:0] pressed;
      logic [3:0] led;
   } vec_t;

   vec_t vec [20];

   int         checks;
   int         failures;
   int         kcnt;
   int         npulse;
   logic [3:0] press_acc;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (k=%0d)", name, act, exp, kcnt);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, kcnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      kcnt++;
      if (o_press != 4'b0000) begin
         npulse++;
         press_acc |= o_press;
      end
   endtask

   task automatic run_to(input int target);
      while (kcnt < target) step();
   endtask

   task automatic do_reset(input logic [3:0] mask);
      rst_n     = 1'b0;
      i_clear   = 1'b0;
      held_mask = mask;
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      kcnt      = 0;
      npulse    = 0;
      press_acc = '0;
   endtask

   task automatic clr_mon();
      npulse    = 0;
      press_acc = '0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      kcnt      = 0;
      npulse    = 0;
      press_acc = '0;
      rst_n     = 1'b0;
      i_clear   = 1'b0;
      held_mask = '0;

      vec[0]  = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[1]  = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[2]  = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[3]  = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[4]  = '{4'b0000, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b1111};
      vec[5]  = '{4'b0000, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b1111};
      vec[6]  = '{4'b0000, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b1111};
      vec[7]  = '{4'b0000, 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b1111};
      vec[8]  = '{4'b0000, 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b1111};
      vec[9]  = '{4'b0000, 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b1111};
      vec[10] = '{4'b0000, 1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b1111};
      vec[11] = '{4'b0000, 1'b0, 4'b1011, 4'b0000, 4'b0000, 4'b1111};
      vec[12] = '{4'b0000, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b1111};
      vec[13] = '{4'b0000, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b1111};
      vec[14] = '{4'b0000, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b1111};
      vec[15] = '{4'b0000, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b1111};
      vec[16] = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[17] = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[18] = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};
      vec[19] = '{4'b0000, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b1111};

      // Reset values and row rotation
      do_reset(4'b0000);
      for (int i = 0; i < 20; i++) begin
         if (i > 0) step();
         chk($sformatf("rot[%0d] scan", i), o_scan, vec[i].scan);
         chk($sformatf("rot[%0d] press", i), o_press, vec[i].press);
         chk($sformatf("rot[%0d] pressed", i), o_pressed, vec[i].pressed);
         chk($sformatf("rot[%0d] led", i), o_led_n, vec[i].led);
         held_mask = vec[i].mask;
         i_clear   = vec[i].clr;
      end
      i_clear = 1'b0;

      // Press, release, second press on row 2
      do_reset(4'b0100);
      run_to(59);
      chk_int("p1 no early pulse", npulse, 0);
      chk("p1 pressed before", o_pressed, 4'b0000);
      step();
      chk("p1 press pulse", o_press, 4'b0100);
      chk("p1 pressed", o_pressed, 4'b0100);
      chk("p1 led", o_led_n, 4'b1011);
      held_mask = 4'b0000;
      step();
      chk("p1 pulse one clock", o_press, 4'b0000);
      clr_mon();
      run_to(123);
      chk("rel pressed before", o_pressed, 4'b0100);
      step();
      chk("rel pressed", o_pressed, 4'b0000);
      chk("rel led", o_led_n, 4'b1011);
      chk_int("rel no pulse", npulse, 0);
      held_mask = 4'b0100;
      run_to(187);
      chk("p2 led before", o_led_n, 4'b1011);
      chk_int("p2 no early pulse", npulse, 0);
      step();
      chk("p2 press pulse", o_press, 4'b0100);
      chk("p2 led", o_led_n, 4'b1111);

      // Bounce on row 1: P,P,P,R then P,P,P,P
      do_reset(4'b0010);
      run_to(40);
      held_mask = 4'b0000;
      run_to(56);
      held_mask = 4'b0010;
      run_to(119);
      chk_int("bounce no pulse", npulse, 0);
      chk("bounce pressed", o_pressed, 4'b0000);
      step();
      chk("bounce press", o_press, 4'b0010);
      chk("bounce pressed after", o_pressed, 4'b0010);
      chk("bounce led", o_led_n, 4'b1101);

      // Asynchronous reset mid-scan takes effect without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("async scan", o_scan, 4'b1110);
      chk("async press", o_press, 4'b0000);
      chk("async pressed", o_pressed, 4'b0000);
      chk("async led", o_led_n, 4'b1111);

      // Clear colliding with a row-3 press
      do_reset(4'b1001);
      run_to(52);
      chk("clr row0 press", o_press, 4'b0001);
      chk("clr led lit", o_led_n, 4'b1110);
      run_to(63);
      chk("clr led before", o_led_n, 4'b1110);
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      chk("clr press pulse", o_press, 4'b1000);
      chk("clr led", o_led_n, 4'b1111);
      chk("clr pressed kept", o_pressed, 4'b1001);
      step();
      chk("clr pulse one clock", o_press, 4'b0000);

      // Reset mid-debounce discards the 3 collected row-0 samples
      do_reset(4'b0001);
      run_to(40);
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      kcnt      = 0;
      npulse    = 0;
      press_acc = '0;
      run_to(51);
      chk_int("rstdb no early pulse", npulse, 0);
      chk("rstdb pressed", o_pressed, 4'b0000);
      step();
      chk("rstdb press", o_press, 4'b0001);
      chk("rstdb led", o_led_n, 4'b1110);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
